uart_rx_core: RTL

- Serial receive engine for the UART peripheral; sits directly upstream of the RX FIFO / register file inside the AXI-lite UART.
- Synchronises the asynchronous uart_rx line, validates the start bit, and samples 8 data bits LSB-first with 3-point majority at mid-bit.
- Optionally checks a parity bit, then checks the stop bit.
- Presents each good byte on a one-entry valid/ready holding register; reports framing, parity, overrun and break events as single-cycle pulses.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx_core.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART receive path.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Rounded clock-to-baud ratio.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw serial line plus a 3-sample history
// giving falling-edge detect and a majority vote.
module uart_rx_sync (
    input  logic aclk_i,
    input  logic aresetn_i,
    input  logic rx_i,
    output logic rxs_o,
    output logic fall_edge_c_o,
    output logic vote_c_o
);

    logic       meta_q;
    logic       rxs_q;
    logic [1:0] hist_q;

    // Flops reset to the idle-high line level so reset release is not an edge.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
            hist_q <= 2'b11;
        end else begin
            meta_q <= rx_i;
            rxs_q  <= meta_q;
            hist_q <= {hist_q[0], rxs_q};
        end
    end

    assign rxs_o         = rxs_q;
    assign fall_edge_c_o = hist_q[0] & ~rxs_q;
    assign vote_c_o      = (rxs_q & hist_q[0]) | (rxs_q & hist_q[1]) | (hist_q[0] & hist_q[1]);

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: start-bit validation, mid-bit majority sampling,
// optional parity, stop check and a one-entry valid/ready holding register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 10_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun,
    output logic                 rx_break,
    output logic                 rx_busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(HALF_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

    logic rxs;
    logic fall_edge_c;
    logic vote_c;

    uart_rx_sync u_sync (
        .aclk_i        (aclk),
        .aresetn_i     (aresetn),
        .rx_i          (uart_rx),
        .rxs_o         (rxs),
        .fall_edge_c_o (fall_edge_c),
        .vote_c_o      (vote_c)
    );

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_q, frame_d;
    logic                 parity_q, parity_d;
    logic                 overrun_q, overrun_d;
    logic                 break_q, break_d;
    logic                 busy_q, busy_d;
    logic                 deliver_c;
    logic                 par_ok_c;

    assign par_ok_c = !PARITY_EN
                   || (par_bit_q == (^shift_q ^ (PARITY_ODD ? PAR_ODD : PAR_EVEN)));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            parity_q  <= 1'b0;
            overrun_q <= 1'b0;
            break_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            frame_q   <= frame_d;
            parity_q  <= parity_d;
            overrun_q <= overrun_d;
            break_q   <= break_d;
            busy_q    <= busy_d;
        end
    end

    // Bit-period counting is aligned to bit boundaries: START runs a full bit
    // (glitch check at its middle), so later decisions at CNT_SAMPLE are mid-bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        data_d    = data_q;
        valid_d   = valid_q & ~rx_ready;
        frame_d   = 1'b0;
        parity_d  = 1'b0;
        overrun_d = 1'b0;
        break_d   = 1'b0;
        deliver_c = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (fall_edge_c) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF && rxs) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (cnt_q == CNT_SAMPLE) begin
                    shift_d   = {vote_c, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == IDX_W'(DATA_BITS)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == CNT_SAMPLE) begin
                    par_bit_d = vote_c;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end
            end
            STOP: begin
                // Resolve at mid stop bit so a following start bit is not missed.
                if (cnt_q == CNT_SAMPLE) begin
                    cnt_d = '0;
                    if (vote_c) begin
                        state_d = IDLE;
                        if (par_ok_c) begin
                            deliver_c = 1'b1;
                        end else begin
                            parity_d = 1'b1;
                        end
                    end else begin
                        state_d = WAIT_IDLE;
                        if (shift_q == '0 && !(PARITY_EN && par_bit_q)) begin
                            break_d = 1'b1;
                        end else begin
                            frame_d = 1'b1;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A same-cycle accept frees the holding register for the new byte.
        if (deliver_c) begin
            if (valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign err_frame   = frame_q;
    assign err_parity  = parity_q;
    assign err_overrun = overrun_q;
    assign rx_break    = break_q;
    assign rx_busy     = busy_q;

endmodule
